// File: rtl/seq_match_ctrl.sv
// Run controller for the serial pattern detector: latches config, arms on start, counts matches, ends on target/timeout/abort.
// All outputs registered (match/done one cycle after the deciding bit); define SEQ_OVERLAP_EN to count overlapping matches.
module seq_match_ctrl #(
  parameter int  PAT_W = 8,
  parameter int  CNT_W = 8,
  parameter int  TMO_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TMO_W-1:0] cfg_tmo,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timeout,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
  logic [CNT_W-1:0] cfg_target_q, cfg_target_d;
  logic [TMO_W-1:0] cfg_tmo_q, cfg_tmo_d;
  logic [PAT_W-2:0] sr_q, sr_d;
  logic [LEN_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             busy_q, busy_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             cfg_err_q, cfg_err_d;

  logic             active;
  logic             bit_acc;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] len_mask;
  logic             cfg_ok;
  logic [LEN_W-1:0] fill_inc;
  logic             fill_full;
  logic             cmp_en;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             tgt_hit;
  logic [TMO_W-1:0] tmo_inc;
  logic             tmo_hit;

  // The shift register only keeps PAT_W-1 bits of history; the incoming bit completes the window.
  assign active    = (state_q == S_FILL) || (state_q == S_RUN);
  assign bit_acc   = in_valid && active;
  assign window    = {sr_q, in_bit};
  assign cfg_ok    = (cfg_len_q != '0) && (cfg_len_q <= LEN_W'(PAT_W)) && (cfg_target_q != '0);
  assign fill_inc  = fill_cnt_q + LEN_W'(1);
  assign fill_full = (fill_inc == cfg_len_q);
  assign cmp_en    = bit_acc && ((state_q == S_RUN) || fill_full);
  assign hit       = cmp_en && ((window & len_mask) == (cfg_pat_q & len_mask));
  assign cnt_inc   = match_cnt_q + CNT_W'(1);
  assign tgt_hit   = hit && (cnt_inc == cfg_target_q);
  assign tmo_inc   = tmo_cnt_q + TMO_W'(1);
  assign tmo_hit   = (cfg_tmo_q != '0) && (tmo_inc == cfg_tmo_q);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(cfg_len_q));
    end
  end

  always_comb begin
    state_d      = state_q;
    cfg_pat_d    = cfg_pat_q;
    cfg_len_d    = cfg_len_q;
    cfg_target_d = cfg_target_q;
    cfg_tmo_d    = cfg_tmo_q;
    sr_d         = sr_q;
    fill_cnt_d   = fill_cnt_q;
    match_cnt_d  = match_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    match_d      = 1'b0;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    timeout_d    = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          cfg_pat_d    = cfg_pat;
          cfg_len_d    = cfg_len;
          cfg_target_d = cfg_target;
          cfg_tmo_d    = cfg_tmo;
        end
        // start is judged against the config already latched, not a same-cycle write.
        if (start) begin
          if (!cfg_ok) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = S_FILL;
            sr_d        = '0;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
            tmo_cnt_d   = '0;
            timeout_d   = 1'b0;
          end
        end
      end

      S_FILL, S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_inc;
          if (bit_acc) begin
            sr_d = window[PAT_W-2:0];
            if (state_q == S_FILL) begin
              if (fill_full) state_d = S_RUN;
              else           fill_cnt_d = fill_inc;
            end
          end
          if (hit) begin
            match_d     = 1'b1;
            match_cnt_d = cnt_inc;
`ifdef SEQ_OVERLAP_EN
            state_d     = S_RUN;
`else
            state_d     = S_FILL;
            fill_cnt_d  = '0;
            sr_d        = '0;
`endif
          end
          // Reaching the target wins over a coincident timeout.
          if (tgt_hit) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (tmo_hit) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_FILL) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cfg_pat_q    <= '0;
      cfg_len_q    <= '0;
      cfg_target_q <= '0;
      cfg_tmo_q    <= '0;
      sr_q         <= '0;
      fill_cnt_q   <= '0;
      match_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      busy_q       <= 1'b0;
      match_q      <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_pat_q    <= cfg_pat_d;
      cfg_len_q    <= cfg_len_d;
      cfg_target_q <= cfg_target_d;
      cfg_tmo_q    <= cfg_tmo_d;
      sr_q         <= sr_d;
      fill_cnt_q   <= fill_cnt_d;
      match_cnt_q  <= match_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      busy_q       <= busy_d;
      match_q      <= match_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign busy      = busy_q;
  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cfg_err   = cfg_err_q;

  // A running count can never have reached its target, and a finished run is never busy.
  a_cnt_below_target: assert property (@(posedge clk) disable iff (!rst)
    busy_q |-> (match_cnt_q < cfg_target_q));
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst)
    !(done_q && busy_q));

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl with hand-computed expectations; flags = {busy,match,done,timeout,cfg_err}.
module tb_seq_match_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic [7:0] cfg_target;
  logic [15:0] cfg_tmo;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       in_bit;
  logic       busy;
  logic       match;
  logic [7:0] match_cnt;
  logic       done;
  logic       timeout;
  logic       cfg_err;
  logic [4:0] flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign flags = {busy, match, done, timeout, cfg_err};

  seq_match_ctrl #(.PAT_W(8), .CNT_W(8), .TMO_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pat    (cfg_pat),
    .cfg_len    (cfg_len),
    .cfg_target (cfg_target),
    .cfg_tmo    (cfg_tmo),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .busy       (busy),
    .match      (match),
    .match_cnt  (match_cnt),
    .done       (done),
    .timeout    (timeout),
    .cfg_err    (cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t,
                           input logic [15:0] tm);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_target = t; cfg_tmo = tm;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_hold: flags=%b cnt=%0d, want flags=00000 cnt=0", flags, match_cnt);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_release: flags=%b cnt=%0d, want flags=00000 cnt=0", flags, match_cnt);
    end
  endtask

  task automatic test_cfg_err();
    pulse_start();
    n_checks++;
    if (flags !== 5'b00001) begin
      n_fail++; $display("FAIL cfg_err_unconfigured: flags=%b want 00001", flags);
    end
    tick();
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL cfg_err_one_cycle: flags=%b want 00000", flags);
    end
    configure(8'h05, 4'd3, 8'd0, 16'd0);
    pulse_start();
    n_checks++;
    if (flags !== 5'b00001) begin
      n_fail++; $display("FAIL cfg_err_target0: flags=%b want 00001", flags);
    end
    configure(8'h05, 4'd9, 8'd1, 16'd0);
    pulse_start();
    n_checks++;
    if (flags !== 5'b00001) begin
      n_fail++; $display("FAIL cfg_err_len_too_big: flags=%b want 00001", flags);
    end
    // Same-cycle write must not affect this start: latched len is still 9.
    cfg_we = 1'b1; cfg_pat = 8'h05; cfg_len = 4'd3; cfg_target = 8'd1; cfg_tmo = 16'd0; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    n_checks++;
    if (flags !== 5'b00001) begin
      n_fail++; $display("FAIL cfg_err_same_cycle_we: flags=%b want 00001", flags);
    end
    pulse_start();
    n_checks++;
    if (flags !== 5'b10000) begin
      n_fail++; $display("FAIL start_after_we: flags=%b want 10000", flags);
    end
    pulse_abort();
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL abort_clean: flags=%b want 00000", flags);
    end
  endtask

  task automatic test_nonoverlap();
    logic       vv [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       bb [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] ef [7] = '{5'b10000, 5'b10000, 5'b10000, 5'b11000, 5'b10000, 5'b10000, 5'b01100};
    logic [7:0] ec [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
    configure(8'hF5, 4'd3, 8'd2, 16'd0);
    pulse_start();
    n_checks++;
    if (flags !== 5'b10000 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL nonoverlap_start: flags=%b cnt=%0d, want 10000 cnt=0", flags, match_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      in_valid = vv[i]; in_bit = bb[i];
      tick();
      n_checks++;
      if (flags !== ef[i] || match_cnt !== ec[i]) begin
        n_fail++; $display("FAIL nonoverlap_step%0d: flags=%b cnt=%0d, want flags=%b cnt=%0d",
                           i, flags, match_cnt, ef[i], ec[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd2) begin
      n_fail++; $display("FAIL nonoverlap_idle: flags=%b cnt=%0d, want 00000 cnt=2", flags, match_cnt);
    end
  endtask

  task automatic test_overlap_window();
    logic       bb [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef SEQ_OVERLAP_EN
    logic [4:0] ef [5] = '{5'b10000, 5'b10000, 5'b11000, 5'b10000, 5'b01100};
    logic [7:0] ec [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
`else
    logic [4:0] ef [5] = '{5'b10000, 5'b10000, 5'b11000, 5'b10000, 5'b10000};
    logic [7:0] ec [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
`endif
    configure(8'h05, 4'd3, 8'd2, 16'd0);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = bb[i];
      tick();
      n_checks++;
      if (flags !== ef[i] || match_cnt !== ec[i]) begin
        n_fail++; $display("FAIL overlap_step%0d: flags=%b cnt=%0d, want flags=%b cnt=%0d",
                           i, flags, match_cnt, ef[i], ec[i]);
      end
    end
    in_valid = 1'b0;
`ifdef SEQ_OVERLAP_EN
    tick();
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd2) begin
      n_fail++; $display("FAIL overlap_end: flags=%b cnt=%0d, want 00000 cnt=2", flags, match_cnt);
    end
`else
    pulse_abort();
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL overlap_end: flags=%b cnt=%0d, want 00000 cnt=1", flags, match_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    logic [4:0] want;
    configure(8'h05, 4'd3, 8'd1, 16'd10);
    pulse_start();
    n_checks++;
    if (flags !== 5'b10000) begin
      n_fail++; $display("FAIL timeout_start: flags=%b want 10000", flags);
    end
    for (int n = 1; n <= 10; n++) begin
      tick();
      want = (n < 10) ? 5'b10000 : 5'b00110;
      n_checks++;
      if (flags !== want || match_cnt !== 8'd0) begin
        n_fail++; $display("FAIL timeout_cycle%0d: flags=%b cnt=%0d, want flags=%b cnt=0",
                           n, flags, match_cnt, want);
      end
    end
    tick();
    n_checks++;
    if (flags !== 5'b00010) begin
      n_fail++; $display("FAIL timeout_held: flags=%b want 00010", flags);
    end
    configure(8'h05, 4'd3, 8'd1, 16'd0);
    n_checks++;
    if (flags !== 5'b00010) begin
      n_fail++; $display("FAIL timeout_held_cfg: flags=%b want 00010", flags);
    end
    pulse_start();
    n_checks++;
    if (flags !== 5'b10000) begin
      n_fail++; $display("FAIL timeout_cleared_by_start: flags=%b want 10000", flags);
    end
    pulse_abort();
  endtask

  task automatic test_priority_back_to_back();
    logic       bb [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0] ef [3] = '{5'b10000, 5'b10000, 5'b01100};
    configure(8'h05, 4'd3, 8'd1, 16'd3);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = bb[i];
      tick();
      n_checks++;
      if (flags !== ef[i]) begin
        n_fail++; $display("FAIL prio_step%0d: flags=%b want %b", i, flags, ef[i]);
      end
    end
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL start_in_done_ignored: flags=%b cnt=%0d, want 00000 cnt=1", flags, match_cnt);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (flags !== 5'b10000 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL back_to_back_start: flags=%b cnt=%0d, want 10000 cnt=0", flags, match_cnt);
    end
    pulse_abort();
  endtask

  task automatic test_len_bounds();
    logic [7:0] p = 8'hA5;
    logic       bb [3] = '{1'b0, 1'b1, 1'b1};
    logic [4:0] ef [3] = '{5'b10000, 5'b11000, 5'b01100};
    logic [7:0] ec [3] = '{8'd0, 8'd1, 8'd2};
    configure(p, 4'd8, 8'd1, 16'd0);
    pulse_start();
    for (int i = 7; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = p[i];
      tick();
      n_checks++;
      if (flags !== ((i > 0) ? 5'b10000 : 5'b01100)) begin
        n_fail++; $display("FAIL len8_bit%0d: flags=%b cnt=%0d", i, flags, match_cnt);
      end
    end
    in_valid = 1'b0;
    tick();
    configure(8'h01, 4'd1, 8'd2, 16'd0);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = bb[i];
      tick();
      n_checks++;
      if (flags !== ef[i] || match_cnt !== ec[i]) begin
        n_fail++; $display("FAIL len1_step%0d: flags=%b cnt=%0d, want flags=%b cnt=%0d",
                           i, flags, match_cnt, ef[i], ec[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    configure(8'h05, 4'd3, 8'd3, 16'd0);
    pulse_start();
    in_valid = 1'b1;
    in_bit = 1'b1; tick();
    in_bit = 1'b0; tick();
    in_bit = 1'b1; tick();
    in_valid = 1'b0;
    n_checks++;
    if (flags !== 5'b11000 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL abort_first_match: flags=%b cnt=%0d, want 11000 cnt=1", flags, match_cnt);
    end
    cfg_we = 1'b1; cfg_pat = 8'h00; cfg_target = 8'd1;
    tick();
    cfg_we = 1'b0;
    n_checks++;
    if (flags !== 5'b10000 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL cfg_we_while_busy: flags=%b cnt=%0d, want 10000 cnt=1", flags, match_cnt);
    end
    abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL abort_to_idle: flags=%b cnt=%0d, want 00000 cnt=1", flags, match_cnt);
    end
    tick();
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL abort_no_done: flags=%b cnt=%0d, want 00000 cnt=1", flags, match_cnt);
    end
    pulse_start();
    n_checks++;
    if (flags !== 5'b10000 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL restart_clears_cnt: flags=%b cnt=%0d, want 10000 cnt=0", flags, match_cnt);
    end
    in_valid = 1'b1;
    in_bit = 1'b1; tick();
    in_bit = 1'b0; tick();
    in_bit = 1'b1; tick();
    in_valid = 1'b0;
    n_checks++;
    if (flags !== 5'b11000 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL config_kept: flags=%b cnt=%0d, want 11000 cnt=1", flags, match_cnt);
    end
    pulse_abort();
  endtask

  task automatic test_reset_midrun();
    configure(8'h05, 4'd3, 8'd3, 16'd0);
    pulse_start();
    in_valid = 1'b1;
    in_bit = 1'b1; tick();
    in_bit = 1'b0; tick();
    in_bit = 1'b1; tick();
    in_bit = 1'b1; tick();
    in_bit = 1'b0; tick();
    in_bit = 1'b1; rst = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (flags !== 5'b00000 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_midrun: flags=%b cnt=%0d, want 00000 cnt=0", flags, match_cnt);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL reset_midrun_idle: flags=%b want 00000", flags);
    end
    pulse_start();
    n_checks++;
    if (flags !== 5'b00001) begin
      n_fail++; $display("FAIL reset_clears_cfg: flags=%b want 00001", flags);
    end
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_target = '0; cfg_tmo = '0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    test_reset();
    test_cfg_err();
    test_nonoverlap();
    test_overlap_window();
    test_timeout();
    test_priority_back_to_back();
    test_len_bounds();
    test_abort();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
